// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle control sequencer for the MIPS datapath
//
// Purpose:
//   Accepts one instruction word per valid/ready handshake and steps it through
//   DECODE -> EXEC -> (MEM) -> WB. It drives the datapath selects, the ALU
//   control and one-shot regfile/memory strobes. Every output comes straight
//   from a flop, so the edge-triggered regfile and memory see glitch-free
//   strobes with exactly one rising edge per access.
//
// Parameters:
//   MEM_WAIT    cycles spent in MEM (1..15); the memory strobe is held throughout
//   CNT_W       width of the retired-instruction counter
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-low reset
//   instrword    in   instruction word, sampled only on accept
//   instr_valid  in   instrword is valid
//   instr_ready  out  controller can accept (IDLE only)
//   regwrite     out  regfile write strobe
//   memread      out  data memory read strobe
//   memwrite     out  data memory write strobe
//   memtoreg     out  writeback source: 1 = memory, 0 = ALU
//   regdst       out  destination: 1 = rd, 0 = rt
//   alusrc       out  ALU operand 2: 1 = sign-extended imm, 0 = rt data
//   aluop        out  2 = R-type, 0 = LW/SW
//   aluctrl      out  ALU function code
//   busy         out  instruction in flight
//   done         out  pulse in the final cycle of an instruction
//   illegal      out  pulse when an unsupported encoding is decoded
//   retired_cnt  out  completed-instruction count (wraps)

module mips_multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instrword,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic [3:0]       aluctrl,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    C_RTYPE = 2'd0,
    C_LW    = 2'd1,
    C_SW    = 2'd2,
    C_ILL   = 2'd3
  } cls_e;

  // Countdown reload: the MEM state ends when the counter reads zero.
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  cls_e             cls_q, cls_d;
  logic [3:0]       fn_q, fn_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             regwrite_q, regwrite_d;
  logic             memread_q, memread_d;
  logic             memwrite_q, memwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic             regdst_q, regdst_d;
  logic             alusrc_q, alusrc_d;
  logic [1:0]       aluop_q, aluop_d;
  logic [3:0]       aluctrl_q, aluctrl_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  cls_e             dec_cls;
  logic [3:0]       dec_fn;
  logic             sel_active;
  logic             dst_nonzero;

  // Only the register-number fields of IR are needed after accept.
  logic             unused_ir;
  assign unused_ir = ^{ir_q[31:21], ir_q[10:0]};

  // The incoming word is classified at accept time so that the illegal
  // flag can already be registered for the DECODE cycle.
  always_comb begin
    dec_cls = C_ILL;
    dec_fn  = 4'd0;
    case (instrword[31:26])
      6'd0: begin
        case (instrword[5:0])
          6'd32:   begin dec_cls = C_RTYPE; dec_fn = 4'd2;  end
          6'd34:   begin dec_cls = C_RTYPE; dec_fn = 4'd6;  end
          6'd36:   begin dec_cls = C_RTYPE; dec_fn = 4'd0;  end
          6'd37:   begin dec_cls = C_RTYPE; dec_fn = 4'd1;  end
          6'd39:   begin dec_cls = C_RTYPE; dec_fn = 4'd12; end
          6'd42:   begin dec_cls = C_RTYPE; dec_fn = 4'd7;  end
          default: begin dec_cls = C_ILL;   dec_fn = 4'd0;  end
        endcase
      end
      6'd35:   begin dec_cls = C_LW;  dec_fn = 4'd2; end
      6'd43:   begin dec_cls = C_SW;  dec_fn = 4'd2; end
      default: begin dec_cls = C_ILL; dec_fn = 4'd0; end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cls_d   = cls_q;
    fn_d    = fn_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instrword;
          cls_d   = dec_cls;
          fn_d    = dec_fn;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (cls_q == C_ILL) ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        if (cls_q == C_RTYPE) begin
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
          wait_d  = WAIT_INIT;
        end
      end
      S_MEM: begin
        if (wait_q == 4'd0) begin
          state_d = (cls_q == C_LW) ? S_WB : S_IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state and registered, so each output
  // flop holds the value belonging to the state being entered.
  always_comb begin
    sel_active  = (state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB);
    dst_nonzero = (cls_d == C_RTYPE) ? (ir_d[15:11] != 5'd0) : (ir_d[20:16] != 5'd0);

    ready_d    = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    illegal_d  = (state_d == S_DECODE) && (cls_d == C_ILL);
    regdst_d   = sel_active && (cls_d == C_RTYPE);
    alusrc_d   = sel_active && ((cls_d == C_LW) || (cls_d == C_SW));
    memtoreg_d = sel_active && (cls_d == C_LW);
    aluop_d    = (sel_active && (cls_d == C_RTYPE)) ? 2'd2 : 2'd0;
    aluctrl_d  = sel_active ? fn_d : 4'd0;
    memread_d  = (state_d == S_MEM) && (cls_d == C_LW);
    memwrite_d = (state_d == S_MEM) && (cls_d == C_SW);
    // A $0 destination still completes, it just never pulses regwrite.
    regwrite_d = (state_d == S_WB) && dst_nonzero;
    // SW retires in its last MEM cycle; everything else retires in WB.
    done_d     = (state_d == S_WB) ||
                 ((state_d == S_MEM) && (cls_d == C_SW) && (wait_d == 4'd0));
    cnt_d      = cnt_q + CNT_W'(done_d);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ir_q       <= 32'd0;
      cls_q      <= C_RTYPE;
      fn_q       <= 4'd0;
      wait_q     <= 4'd0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      regdst_q   <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= 2'd0;
      aluctrl_q  <= 4'd0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      cls_q      <= cls_d;
      fn_q       <= fn_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      regdst_q   <= regdst_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      aluctrl_q  <= aluctrl_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign regwrite    = regwrite_q;
  assign memread     = memread_q;
  assign memwrite    = memwrite_q;
  assign memtoreg    = memtoreg_q;
  assign regdst      = regdst_q;
  assign alusrc      = alusrc_q;
  assign aluop       = aluop_q;
  assign aluctrl     = aluctrl_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instrword;
  logic        valid_a, valid_b;

  always #5 clock = ~clock;

  logic        a_ready, a_regwrite, a_memread, a_memwrite, a_memtoreg, a_regdst, a_alusrc;
  logic [1:0]  a_aluop;
  logic [3:0]  a_aluctrl;
  logic        a_busy, a_done, a_illegal;
  logic [1:0]  a_cnt;

  logic        b_ready, b_regwrite, b_memread, b_memwrite, b_memtoreg, b_regdst, b_alusrc;
  logic [1:0]  b_aluop;
  logic [3:0]  b_aluctrl;
  logic        b_busy, b_done, b_illegal;
  logic [15:0] b_cnt;

  mips_multicycle_ctrl #(.MEM_WAIT(1), .CNT_W(2)) u_dut_a (
    .clock(clock), .reset(reset), .instrword(instrword), .instr_valid(valid_a),
    .instr_ready(a_ready), .regwrite(a_regwrite), .memread(a_memread),
    .memwrite(a_memwrite), .memtoreg(a_memtoreg), .regdst(a_regdst),
    .alusrc(a_alusrc), .aluop(a_aluop), .aluctrl(a_aluctrl), .busy(a_busy),
    .done(a_done), .illegal(a_illegal), .retired_cnt(a_cnt)
  );

  mips_multicycle_ctrl #(.MEM_WAIT(3), .CNT_W(16)) u_dut_b (
    .clock(clock), .reset(reset), .instrword(instrword), .instr_valid(valid_b),
    .instr_ready(b_ready), .regwrite(b_regwrite), .memread(b_memread),
    .memwrite(b_memwrite), .memtoreg(b_memtoreg), .regdst(b_regdst),
    .alusrc(b_alusrc), .aluop(b_aluop), .aluctrl(b_aluctrl), .busy(b_busy),
    .done(b_done), .illegal(b_illegal), .retired_cnt(b_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [5:0]  funct_tab [4];
  logic [3:0]  code_tab  [4];
  logic [31:0] w;
  int          n_done, n_wr, n_acc;

  initial begin
    funct_tab[0] = 6'd34; code_tab[0] = 4'd6;
    funct_tab[1] = 6'd36; code_tab[1] = 4'd0;
    funct_tab[2] = 6'd37; code_tab[2] = 4'd1;
    funct_tab[3] = 6'd39; code_tab[3] = 4'd12;

    reset = 1'b0; instrword = 32'd0; valid_a = 1'b0; valid_b = 1'b0;
    step(2);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_a_outs", {20'd0, a_regwrite, a_memread, a_memwrite, a_memtoreg, a_regdst,
                         a_alusrc, a_aluop, a_aluctrl}, 32'd0);
    check("rst_a_pulses", {30'd0, a_done, a_illegal}, 32'd0);
    check("rst_a_cnt", 32'(a_cnt), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    check("rst_b_cnt", 32'(b_cnt), 32'd0);
    reset = 1'b1;

    // Four back-to-back adds with valid held high: one accept per done, count wraps.
    instrword = 32'h00221820; valid_a = 1'b1;
    n_done = 0; n_wr = 0; n_acc = (a_ready && valid_a) ? 1 : 0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (a_done) n_done++;
      if (a_regwrite) n_wr++;
      if (i == 11) check("wrap_cnt_3", 32'(a_cnt), 32'd3);
      if (i == 15) begin
        check("wrap_cnt_0", 32'(a_cnt), 32'd0);
        valid_a = 1'b0;
      end
      if (a_ready && valid_a) n_acc++;
    end
    check("held_accepts", 32'(n_acc), 32'd4);
    check("held_dones", 32'(n_done), 32'd4);
    check("held_regwrites", 32'(n_wr), 32'd4);
    check("held_ready_end", 32'(a_ready), 32'd1);

    // add $3,$1,$2 with a garbage word presented while busy.
    instrword = 32'h00221820; valid_a = 1'b1;
    step(1);
    check("add_t1_ready", 32'(a_ready), 32'd0);
    check("add_t1_busy", 32'(a_busy), 32'd1);
    check("add_t1_regdst", 32'(a_regdst), 32'd0);
    instrword = 32'h10000000;
    step(1);
    check("add_t2_regdst", 32'(a_regdst), 32'd1);
    check("add_t2_aluctrl", 32'(a_aluctrl), 32'd2);
    check("add_t2_aluop", 32'(a_aluop), 32'd2);
    check("add_t2_alusrc", 32'(a_alusrc), 32'd0);
    check("add_t2_regwrite", 32'(a_regwrite), 32'd0);
    step(1);
    check("add_t3_regwrite", 32'(a_regwrite), 32'd1);
    check("add_t3_done", 32'(a_done), 32'd1);
    check("add_t3_cnt", 32'(a_cnt), 32'd1);
    valid_a = 1'b0;
    step(1);
    check("add_t4_ready", 32'(a_ready), 32'd1);
    check("add_t4_quiet", {28'd0, a_regwrite, a_done, a_illegal, a_regdst}, 32'd0);

    // sw $5,8($0), MEM_WAIT = 1.
    instrword = 32'hAC050008; valid_a = 1'b1;
    step(1); valid_a = 1'b0;
    step(1);
    check("sw_t2_memwrite", 32'(a_memwrite), 32'd0);
    check("sw_t2_sel", {25'd0, a_alusrc, a_memtoreg, a_aluop, a_regdst, a_regwrite, a_memread},
          32'h40);
    check("sw_t2_aluctrl", 32'(a_aluctrl), 32'd2);
    step(1);
    check("sw_t3_memwrite", 32'(a_memwrite), 32'd1);
    check("sw_t3_done", 32'(a_done), 32'd1);
    check("sw_t3_regwrite", 32'(a_regwrite), 32'd0);
    check("sw_t3_cnt", 32'(a_cnt), 32'd2);
    step(1);
    check("sw_t4_memwrite", 32'(a_memwrite), 32'd0);
    check("sw_t4_ready", 32'(a_ready), 32'd1);

    // beq and an unsupported funct are both illegal.
    instrword = 32'h10000000; valid_a = 1'b1;
    step(1); valid_a = 1'b0;
    check("beq_t1_illegal", 32'(a_illegal), 32'd1);
    check("beq_t1_done", 32'(a_done), 32'd0);
    step(1);
    check("beq_t2_illegal", 32'(a_illegal), 32'd0);
    check("beq_t2_ready", 32'(a_ready), 32'd1);
    check("beq_t2_cnt", 32'(a_cnt), 32'd2);
    check("beq_t2_strobes", {29'd0, a_regwrite, a_memread, a_memwrite}, 32'd0);
    instrword = 32'h00220021; valid_a = 1'b1;
    step(1); valid_a = 1'b0;
    check("addu_illegal", 32'(a_illegal), 32'd1);
    step(1);

    // slt with rd = $0: aluctrl 7, done without regwrite.
    instrword = 32'h0022002A; valid_a = 1'b1;
    step(1); valid_a = 1'b0;
    step(1);
    check("slt_aluctrl", 32'(a_aluctrl), 32'd7);
    step(1);
    check("slt_done", 32'(a_done), 32'd1);
    check("slt_regwrite", 32'(a_regwrite), 32'd0);
    check("slt_cnt", 32'(a_cnt), 32'd3);
    step(1);

    // Remaining R-type function codes.
    for (int k = 0; k < 4; k++) begin
      w = 32'h00221800;
      w[5:0] = funct_tab[k];
      instrword = w; valid_a = 1'b1;
      step(1); valid_a = 1'b0;
      step(1);
      check($sformatf("funct%0d_aluctrl", funct_tab[k]), 32'(a_aluctrl), 32'(code_tab[k]));
      step(1);
      check($sformatf("funct%0d_done", funct_tab[k]), 32'(a_done), 32'd1);
      step(1);
    end

    // lw $5,4($0) on the MEM_WAIT = 3 instance.
    instrword = 32'h8C050004; valid_b = 1'b1;
    step(1); valid_b = 1'b0;
    step(1);
    check("lw_t2_sel", {26'd0, b_alusrc, b_memtoreg, b_aluop, b_regdst, b_memread}, 32'h30);
    check("lw_t2_aluctrl", 32'(b_aluctrl), 32'd2);
    for (int k = 3; k <= 5; k++) begin
      step(1);
      check($sformatf("lw_t%0d_memread", k), 32'(b_memread), 32'd1);
      check($sformatf("lw_t%0d_done_wr", k), {30'd0, b_done, b_regwrite}, 32'd0);
    end
    step(1);
    check("lw_t6_memread", 32'(b_memread), 32'd0);
    check("lw_t6_regwrite", 32'(b_regwrite), 32'd1);
    check("lw_t6_done", 32'(b_done), 32'd1);
    check("lw_t6_memtoreg", 32'(b_memtoreg), 32'd1);
    check("lw_t6_cnt", 32'(b_cnt), 32'd1);
    step(1);
    check("lw_t7_ready", 32'(b_ready), 32'd1);

    // Reset in the middle of an LW MEM phase.
    instrword = 32'h8C050004; valid_b = 1'b1;
    step(1); valid_b = 1'b0;
    step(2);
    check("abort_pre_memread", 32'(b_memread), 32'd1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("abort_memread", 32'(b_memread), 32'd0);
    check("abort_ready", 32'(b_ready), 32'd1);
    check("abort_cnt_b", 32'(b_cnt), 32'd0);
    check("abort_cnt_a", 32'(a_cnt), 32'd0);
    check("abort_pulses", {28'd0, b_done, b_illegal, b_regwrite, b_memtoreg}, 32'd0);
    step(1);
    check("abort_next_strobes", {29'd0, b_regwrite, b_memread, b_memwrite}, 32'd0);
    check("abort_next_done", 32'(b_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
